// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC widths, Q.13 angle constants and pre-processing state encoding
package cordic_pkg;
  localparam int FRAC_W = 13;
  localparam int ANGLE_IN_W = 20;
  localparam int ANGLE_OUT_W = 16;
  localparam int Z_W = ANGLE_IN_W + 1;
  localparam int PI = 25736;
  localparam int HALF_PI = 12868;
  localparam int TWO_PI = 51472;
  localparam logic signed [Z_W-1:0] PI_Z = Z_W'(PI);
  localparam logic signed [Z_W-1:0] HALF_PI_Z = Z_W'(HALF_PI);
  localparam logic signed [Z_W-1:0] TWO_PI_Z = Z_W'(TWO_PI);
  typedef enum logic [1:0] {IDLE, REDUCE, FOLD, OUT} state_e;
endpackage

// File: rtl/pre_processing_unit_if.sv
// pre_processing_unit_if: angle input and folded-angle output handshakes
interface pre_processing_unit_if;
  import cordic_pkg::*;
  logic signed [ANGLE_IN_W-1:0] Angle_in;
  logic Valid_in;
  logic Ready_out;
  logic signed [ANGLE_OUT_W-1:0] Angle_out;
  logic Cos_negate_out;
  logic Valid_out;
  logic Ready_in;
  modport master (
    output Angle_in, Valid_in, Ready_in,
    input Ready_out, Angle_out, Cos_negate_out, Valid_out
  );
  modport slave (
    input Angle_in, Valid_in, Ready_in,
    output Ready_out, Angle_out, Cos_negate_out, Valid_out
  );
endinterface

// File: rtl/pre_processing_unit_angle_fold.sv
// angle_fold: folds an angle in [-pi, pi] into [-pi/2, pi/2] and flags a cos negation
module angle_fold
  import cordic_pkg::*;
(
  input  logic signed [Z_W-1:0]         z,
  output logic signed [ANGLE_OUT_W-1:0] angle,
  output logic                          neg
);
  // pi - z keeps sin and flips cos, so only cos needs correcting downstream
  always_comb begin
    neg = (z > HALF_PI_Z) || (z < -HALF_PI_Z);
    angle = ANGLE_OUT_W'(z > HALF_PI_Z ? PI_Z - z : z < -HALF_PI_Z ? -PI_Z - z : z);
  end
endmodule

// File: rtl/pre_processing_unit.sv
// pre_processing_unit: iterative modulo-2pi reduction and quadrant fold ahead of CORDIC
module pre_processing_unit
  import cordic_pkg::*;
(
  input logic                     Clk_in,
  input logic                     Rst_in,
  pre_processing_unit_if.slave    bus
);
  state_e state_q, state_d;
  logic signed [Z_W-1:0] z_q, z_d;
  logic signed [ANGLE_OUT_W-1:0] angle_q, angle_d, fold_angle;
  logic neg_q, neg_d, fold_neg;
  logic valid_q, valid_d;
  logic ready_q, ready_d;
  logic in_range;
  angle_fold u_fold (.z(z_q), .angle(fold_angle), .neg(fold_neg));
  assign in_range = (z_q <= PI_Z) && (z_q >= -PI_Z);
  // next-state: one 2pi adjustment per REDUCE cycle, outputs captured in FOLD
  always_comb begin
    state_d = state_q;
    z_d = z_q;
    angle_d = angle_q;
    neg_d = neg_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        z_d = (bus.Valid_in && ready_q) ? Z_W'(bus.Angle_in) : z_q;
        state_d = (bus.Valid_in && ready_q) ? REDUCE : IDLE;
      end
      REDUCE: begin
        z_d = z_q > PI_Z ? z_q - TWO_PI_Z : z_q < -PI_Z ? z_q + TWO_PI_Z : z_q;
        state_d = in_range ? FOLD : REDUCE;
      end
      FOLD: begin
        angle_d = fold_angle;
        neg_d = fold_neg;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        valid_d = bus.Ready_in ? 1'b0 : 1'b1;
        state_d = bus.Ready_in ? IDLE : OUT;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  // state and registered outputs; reset drops any in-flight angle
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state_q <= IDLE;
      z_q <= '0;
      angle_q <= '0;
      neg_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      z_q <= z_d;
      angle_q <= angle_d;
      neg_q <= neg_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end
  assign bus.Ready_out = ready_q;
  assign bus.Angle_out = angle_q;
  assign bus.Cos_negate_out = neg_q;
  assign bus.Valid_out = valid_q;
endmodule
